// File: rtl/escalonador_zonas_pkg.sv
// Shared types and helpers for the zone turn-on sequencer.
package escalonador_pkg;

    // Sequencer states: waiting for a request, or holding off the next turn-on
    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Width of the stagger down-counter; it must hold S-1 where S is the
    // stagger length in cycles.
    function automatic int cnt_width(input int stagger_t, input int ticks_per_ms);
        int s;
        s = stagger_t * ticks_per_ms;
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/escalonador_zonas_if.sv
// Request/enable bundle between the zone controllers, the sequencer and the lamp stage.
interface escalonador_zonas_if #(
    parameter int N_ZONES = 4
);
    localparam int IW = $clog2(N_ZONES);

    logic [N_ZONES-1:0] req;
    logic               all_off;
    logic [N_ZONES-1:0] lamp_en;
    logic               grant_valid;
    logic [IW-1:0]      grant_id;
    logic               busy;

    // Controller side: drives requests and the master kill
    modport master (
        output req,
        output all_off,
        input  lamp_en,
        input  grant_valid,
        input  grant_id,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  req,
        input  all_off,
        output lamp_en,
        output grant_valid,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/escalonador_zonas_rr_picker.sv
// Round-robin selector: first set pending bit at or above the pointer, wrapping.
module rr_picker #(
    parameter int N_ZONES = 4,
    localparam int IW = $clog2(N_ZONES)
) (
    input  logic [N_ZONES-1:0] pending,
    input  logic [IW-1:0]      pointer,
    output logic               found,
    output logic [IW-1:0]      idx
);

    // Walk offsets from farthest to nearest so the nearest candidate wins
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N_ZONES - 1; off >= 0; off--) begin
            cand = int'(pointer) + off;
            if (cand >= N_ZONES) begin
                cand = cand - N_ZONES;
            end
            if (pending[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/escalonador_zonas.sv
// Inrush-limiting lamp sequencer: at most one lamp turn-on per stagger window,
// pending zones served round-robin, turn-off always immediate.
module escalonador_zonas
    import escalonador_pkg::*;
#(
    parameter int N_ZONES      = 4,
    parameter int STAGGER_T    = 500,
    parameter int TICKS_PER_MS = 1
) (
    input  logic                clk,
    input  logic                rst,
    escalonador_zonas_if.slave  bus
);

    localparam int S  = STAGGER_T * TICKS_PER_MS;
    localparam int CW = cnt_width(STAGGER_T, TICKS_PER_MS);
    localparam int IW = $clog2(N_ZONES);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [N_ZONES-1:0] lamp_en_q, lamp_en_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic               busy_q, busy_d;

    logic [N_ZONES-1:0] pending;
    logic               found;
    logic [IW-1:0]      idx;
    logic               grant;

    // Zones that want light but are not yet lit
    assign pending = bus.req & ~lamp_en_q;

    rr_picker #(
        .N_ZONES (N_ZONES)
    ) u_picker (
        .pending (pending),
        .pointer (ptr_q),
        .found   (found),
        .idx     (idx)
    );

    // Next-state logic: kill has priority, then turn-offs, window countdown and grants
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        lamp_en_d     = lamp_en_q & bus.req;
        grant_valid_d = 1'b0;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        grant         = 1'b0;

        if (bus.all_off) begin
            lamp_en_d = '0;
            cnt_d     = '0;
            state_d   = IDLE;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant = found;
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (found) begin
                        grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (grant) begin
            lamp_en_d[idx] = 1'b1;
            grant_valid_d  = 1'b1;
            grant_id_d     = idx;
            ptr_d          = (idx == IW'(N_ZONES - 1)) ? '0 : idx + 1'b1;
            cnt_d          = CW'(S - 1);
            state_d        = SETTLE;
            busy_d         = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            lamp_en_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            lamp_en_q     <= lamp_en_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.lamp_en     = lamp_en_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_escalonador_zonas.sv
// Directed test of the zone sequencer with S = 500 cycles.
module tb_escalonador_zonas;

    localparam int N  = 4;
    localparam int S  = 500;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    escalonador_zonas_if #(.N_ZONES(N)) bus ();

    escalonador_zonas #(
        .N_ZONES      (N),
        .STAGGER_T    (500),
        .TICKS_PER_MS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One grant transaction: valid pulse, id and resulting enables
    task automatic chk_grant(input string tag, input int id, input logic [3:0] lamps);
        $display("txn %s: grant_valid=%0b grant_id=%0d lamp_en=%b", tag,
                 bus.grant_valid, bus.grant_id, bus.lamp_en);
        chk({tag, "_gv"},   32'(bus.grant_valid), 32'd1);
        chk({tag, "_id"},   32'(bus.grant_id),    32'(id));
        chk({tag, "_lamp"}, 32'(bus.lamp_en),     32'(lamps));
        chk({tag, "_busy"}, 32'(bus.busy),        32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.all_off = 1'b0;
        step(2);

        // Reset state
        chk("rst_lamp", 32'(bus.lamp_en), 32'd0);
        chk("rst_gv",   32'(bus.grant_valid), 32'd0);
        chk("rst_id",   32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step(1);

        // Single request from idle: 1-cycle latency, busy for S cycles
        bus.req = 4'b0001;
        step(1);
        chk_grant("single", 0, 4'b0001);
        step(1);
        chk("single_pulse_end", 32'(bus.grant_valid), 32'd0);
        step(S - 2);
        chk("single_busy_last", 32'(bus.busy), 32'd1);
        step(1);
        chk("single_busy_drop", 32'(bus.busy), 32'd0);

        // Fresh reset so the pointer is 0, then all four at once
        bus.req = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.req = 4'b1111;
        step(1);
        chk_grant("all_z0", 0, 4'b0001);
        step(S - 1);
        chk("all_gap_gv", 32'(bus.grant_valid), 32'd0);
        chk("all_gap_lamp", 32'(bus.lamp_en), 32'b0001);
        step(1);
        chk_grant("all_z1", 1, 4'b0011);
        step(S);
        chk_grant("all_z2", 2, 4'b0111);
        step(S);
        chk_grant("all_z3", 3, 4'b1111);
        step(S);
        chk("all_idle", 32'(bus.busy), 32'd0);

        // Wrap-around fairness: grant zone 1 so pointer=2, then pending 1011
        bus.req = '0;
        step(1);
        chk("wrap_off", 32'(bus.lamp_en), 32'd0);
        bus.req = 4'b0010;
        step(1);
        chk_grant("wrap_z1", 1, 4'b0010);
        bus.req = '0;
        step(1);
        chk("wrap_z1_off", 32'(bus.lamp_en), 32'd0);
        chk("wrap_settle_busy", 32'(bus.busy), 32'd1);
        step(S - 1);
        chk("wrap_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b1011;
        step(1);
        chk_grant("wrap_z3", 3, 4'b1000);
        step(S);
        chk_grant("wrap_z0", 0, 4'b1001);
        step(S);
        chk_grant("wrap_z1b", 1, 4'b1011);
        step(S);
        chk("wrap_done", 32'(bus.busy), 32'd0);

        // Drop a just-granted zone during SETTLE; pointer is 2 here
        bus.req = '0;
        step(1);
        bus.req = 4'b0100;
        step(1);
        chk_grant("drop_z2", 2, 4'b0100);
        bus.req = 4'b0111;
        step(1);
        bus.req = 4'b0011;
        step(1);
        chk("drop_lamp", 32'(bus.lamp_en), 32'd0);
        chk("drop_busy", 32'(bus.busy), 32'd1);
        step(S - 3);
        chk("drop_pre_gv", 32'(bus.grant_valid), 32'd0);
        chk("drop_pre_lamp", 32'(bus.lamp_en), 32'd0);
        step(1);
        chk_grant("drop_z0", 0, 4'b0001);
        step(S);
        chk_grant("drop_z1", 1, 4'b0011);
        step(S);
        chk("drop_done", 32'(bus.busy), 32'd0);

        // Master kill mid-SETTLE with a queue of three zones; pointer is 2
        bus.req = '0;
        step(1);
        bus.req = 4'b0111;
        step(1);
        chk_grant("kill_z2", 2, 4'b0100);
        step(10);
        bus.all_off = 1'b1;
        step(1);
        chk("kill_lamp", 32'(bus.lamp_en), 32'd0);
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_gv", 32'(bus.grant_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("kill_hold_gv", 32'(bus.grant_valid), 32'd0);
            chk("kill_hold_lamp", 32'(bus.lamp_en), 32'd0);
        end
        bus.all_off = 1'b0;
        step(1);
        chk_grant("kill_rel_z0", 0, 4'b0001);
        step(S);
        chk_grant("kill_rel_z1", 1, 4'b0011);
        step(S);
        chk_grant("kill_rel_z2", 2, 4'b0111);

        // Asynchronous reset mid-SETTLE with all zones requesting
        bus.req = 4'b1111;
        step(20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lamp", 32'(bus.lamp_en), 32'd0);
        chk("arst_gv",   32'(bus.grant_valid), 32'd0);
        chk("arst_id",   32'(bus.grant_id), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        step(1);
        chk("arst_hold", 32'(bus.lamp_en), 32'd0);
        rst = 1'b0;
        step(1);
        chk_grant("arst_z0", 0, 4'b0001);
        step(S);
        chk_grant("arst_z1", 1, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
